texture_bilinear_filter: RTL

- Sits directly downstream of the texel-quad sampler and consumes its texel quad (00/01/10/11) and Q0.16 sub-texel coordinates.
- Produces one filtered RGBA texel per accepted input.
- Two modes: bilinear (two-stage lerp, horizontal then vertical) or nearest (quad element selected from the sub-coordinate MSBs).
- Fixed-latency pipeline with clock-enable stall, a valid bit and a user tag carried alongside for fragment bookkeeping.

---
 rtl/texture_bilinear_filter_pkg.sv | 25 ++
 rtl/texture_lerp8.sv | 40 ++++
 rtl/texture_bilinear_filter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/texture_bilinear_filter_pkg.sv
// ---------------------------------------------------------------------------
// texture_bilinear_filter_pkg
//
// Shared texture definitions for the bilinear filter and its lerp datapath.
//   CHANNEL_WIDTH   : bits per colour channel
//   NUM_CHANNELS    : channels per texel (R, G, B, A)
//   WEIGHT_WIDTH    : Q0.8 interpolation weight width
//   CHANNEL_OFFSET  : LSB position of each channel, index 0 = R ... 3 = A
//   filter_mode_e   : FILTER_NEAREST / FILTER_BILINEAR encodings
// ---------------------------------------------------------------------------
package texture_bilinear_filter_pkg;

    localparam int CHANNEL_WIDTH = 8;
    localparam int NUM_CHANNELS  = 4;
    localparam int WEIGHT_WIDTH  = 8;

    // R at [31:24], G at [23:16], B at [15:8], A at [7:0]
    localparam int CHANNEL_OFFSET [NUM_CHANNELS] = '{24, 16, 8, 0};

    typedef enum logic {
        FILTER_NEAREST  = 1'b0,
        FILTER_BILINEAR = 1'b1
    } filter_mode_e;

endpackage

// File: rtl/texture_lerp8.sv
// ---------------------------------------------------------------------------
// texture_lerp8
//
// Combinational single-channel linear interpolation with rounding:
//   y = (a*(256-w) + b*w + 128) >> 8
// The sum never exceeds 255*256+128, so the result always fits in 8 bits
// and w=0 returns a exactly.
//
// Ports:
//   a, b : channel endpoints
//   w    : Q0.8 weight toward b
//   y    : interpolated channel
// ---------------------------------------------------------------------------
module texture_lerp8
    import texture_bilinear_filter_pkg::*;
(
    input  logic [CHANNEL_WIDTH-1:0] a,
    input  logic [CHANNEL_WIDTH-1:0] b,
    input  logic [WEIGHT_WIDTH-1:0]  w,
    output logic [CHANNEL_WIDTH-1:0] y
);

    localparam int SUM_WIDTH = CHANNEL_WIDTH + WEIGHT_WIDTH + 1;

    logic [WEIGHT_WIDTH:0] w_inv;
    logic [SUM_WIDTH-1:0]  sum;
    logic                  unused_sum_bits;

    assign w_inv = (WEIGHT_WIDTH+1)'(1 << WEIGHT_WIDTH) - {1'b0, w};

    assign sum = SUM_WIDTH'(a) * SUM_WIDTH'(w_inv)
               + SUM_WIDTH'(b) * SUM_WIDTH'(w)
               + SUM_WIDTH'(1 << (WEIGHT_WIDTH - 1));

    assign y = sum[CHANNEL_WIDTH+WEIGHT_WIDTH-1:WEIGHT_WIDTH];

    // Top bit is provably zero; the low byte is the discarded fraction.
    assign unused_sum_bits = ^{sum[SUM_WIDTH-1], sum[WEIGHT_WIDTH-1:0]};

endmodule

// File: rtl/texture_bilinear_filter.sv
// ---------------------------------------------------------------------------
// texture_bilinear_filter
//
// Filters a texel quad from the quad sampler into one RGBA texel.
// Three-stage pipeline, all stages gated by the shared clock enable:
//   S1 : register quad, tag, mode and Q0.8 weights (coord[15:8])
//   S2 : horizontal lerps (top row, bottom row) and nearest selection
//   S3 : vertical lerp or nearest texel into the output register
//
// Handshake: there is no ready. A beat is taken when in_valid=1 on a
// rising aclk edge with ce=1, and leaves on out_* after exactly three
// ce=1 edges. With ce=0 every register (valid, data, tag, mode) holds and
// in_* are ignored. out_texel is meaningful only while out_valid=1.
//
// Ports:
//   aclk, resetn       : clock, asynchronous active-low reset
//   ce                 : pipeline clock enable
//   filterEnable       : 1 = bilinear, 0 = nearest (per beat)
//   in_valid, in_tag   : input beat valid and opaque tag
//   texel00..texel11   : quad at (s,t) = (0,0),(1,0),(0,1),(1,1)
//   texelSubCoordS/T   : Q0.16 position inside the quad
//   out_valid, out_tag : output beat valid and its tag
//   out_texel          : filtered texel
//
// Only PIXEL_WIDTH = 32 (four 8-bit channels) is supported.
// ---------------------------------------------------------------------------
module texture_bilinear_filter
    import texture_bilinear_filter_pkg::*;
#(
    parameter int PIXEL_WIDTH = 32,
    parameter int TAG_WIDTH   = 16
) (
    input  logic                   aclk,
    input  logic                   resetn,
    input  logic                   ce,
    input  logic                   filterEnable,
    input  logic                   in_valid,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    input  logic [PIXEL_WIDTH-1:0] texel00,
    input  logic [PIXEL_WIDTH-1:0] texel01,
    input  logic [PIXEL_WIDTH-1:0] texel10,
    input  logic [PIXEL_WIDTH-1:0] texel11,
    input  logic [15:0]            texelSubCoordS,
    input  logic [15:0]            texelSubCoordT,
    output logic                   out_valid,
    output logic [TAG_WIDTH-1:0]   out_tag,
    output logic [PIXEL_WIDTH-1:0] out_texel
);

    // ---------------- S1 registers ----------------
    logic                    s1_valid;
    logic [TAG_WIDTH-1:0]    s1_tag;
    filter_mode_e            s1_mode;
    logic [WEIGHT_WIDTH-1:0] s1_ws;
    logic [WEIGHT_WIDTH-1:0] s1_wt;
    logic [PIXEL_WIDTH-1:0]  s1_t00;
    logic [PIXEL_WIDTH-1:0]  s1_t01;
    logic [PIXEL_WIDTH-1:0]  s1_t10;
    logic [PIXEL_WIDTH-1:0]  s1_t11;

    // ---------------- S2 registers ----------------
    logic                    s2_valid;
    logic [TAG_WIDTH-1:0]    s2_tag;
    filter_mode_e            s2_mode;
    logic [WEIGHT_WIDTH-1:0] s2_wt;
    logic [PIXEL_WIDTH-1:0]  s2_top;
    logic [PIXEL_WIDTH-1:0]  s2_bot;
    logic [PIXEL_WIDTH-1:0]  s2_near;

    // ---------------- combinational ----------------
    logic [PIXEL_WIDTH-1:0]  top_c;
    logic [PIXEL_WIDTH-1:0]  bot_c;
    logic [PIXEL_WIDTH-1:0]  vert_c;
    logic [PIXEL_WIDTH-1:0]  near_c;
    logic [PIXEL_WIDTH-1:0]  result_c;
    logic [1:0]              near_sel;
    logic                    unused_coord_lsbs;

    // Only the top byte of each coordinate becomes the weight.
    assign unused_coord_lsbs = ^{texelSubCoordS[7:0], texelSubCoordT[7:0]};

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_tag   <= '0;
            s1_mode  <= FILTER_NEAREST;
            s1_ws    <= '0;
            s1_wt    <= '0;
            s1_t00   <= '0;
            s1_t01   <= '0;
            s1_t10   <= '0;
            s1_t11   <= '0;
        end else if (ce) begin
            s1_valid <= in_valid;
            s1_tag   <= in_tag;
            s1_mode  <= filterEnable ? FILTER_BILINEAR : FILTER_NEAREST;
            s1_ws    <= texelSubCoordS[15:8];
            s1_wt    <= texelSubCoordT[15:8];
            s1_t00   <= texel00;
            s1_t01   <= texel01;
            s1_t10   <= texel10;
            s1_t11   <= texel11;
        end
    end

    // Weight MSBs equal the coordinate MSBs, so they pick the nearest texel.
    assign near_sel = {s1_wt[WEIGHT_WIDTH-1], s1_ws[WEIGHT_WIDTH-1]};

    always_comb begin
        near_c = s1_t00;
        case (near_sel)
            2'b00:   near_c = s1_t00;
            2'b01:   near_c = s1_t01;
            2'b10:   near_c = s1_t10;
            default: near_c = s1_t11;
        endcase
    end

    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan
        localparam int OFF = CHANNEL_OFFSET[ch];

        texture_lerp8 u_lerp_top (
            .a (s1_t00[OFF +: CHANNEL_WIDTH]),
            .b (s1_t01[OFF +: CHANNEL_WIDTH]),
            .w (s1_ws),
            .y (top_c[OFF +: CHANNEL_WIDTH])
        );

        texture_lerp8 u_lerp_bot (
            .a (s1_t10[OFF +: CHANNEL_WIDTH]),
            .b (s1_t11[OFF +: CHANNEL_WIDTH]),
            .w (s1_ws),
            .y (bot_c[OFF +: CHANNEL_WIDTH])
        );

        texture_lerp8 u_lerp_vert (
            .a (s2_top[OFF +: CHANNEL_WIDTH]),
            .b (s2_bot[OFF +: CHANNEL_WIDTH]),
            .w (s2_wt),
            .y (vert_c[OFF +: CHANNEL_WIDTH])
        );
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            s2_valid <= 1'b0;
            s2_tag   <= '0;
            s2_mode  <= FILTER_NEAREST;
            s2_wt    <= '0;
            s2_top   <= '0;
            s2_bot   <= '0;
            s2_near  <= '0;
        end else if (ce) begin
            s2_valid <= s1_valid;
            s2_tag   <= s1_tag;
            s2_mode  <= s1_mode;
            s2_wt    <= s1_wt;
            s2_top   <= top_c;
            s2_bot   <= bot_c;
            s2_near  <= near_c;
        end
    end

    // Nearest beats bypass the vertical lerp but still spend the S3 cycle.
    assign result_c = (s2_mode == FILTER_BILINEAR) ? vert_c : s2_near;

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_tag   <= '0;
            out_texel <= '0;
        end else if (ce) begin
            out_valid <= s2_valid;
            out_tag   <= s2_tag;
            out_texel <= result_c;
        end
    end

endmodule
